// File: rtl/link_param_loader_pkg.sv
// Shared decoder parameters: stage encodings, boundary-condition codes,
// link weight width derivation and the loader FSM state type.
package link_param_loader_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_ERASURE_LOADING     = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd6;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd7;

  // Codes 2 and 3 both mean the link does not exist.
  localparam logic [1:0] BC_NORMAL      = 2'd0;
  localparam logic [1:0] BC_BOUNDARY    = 2'd1;
  localparam logic [1:0] BC_NONEXISTENT = 2'd2;

  function automatic int link_bit_width(input int max_weight);
    return $clog2(max_weight + 1);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_PARAM,
    S_LOAD_ERASE,
    S_DONE
  } loader_state_t;

endpackage

// File: rtl/link_param_slot.sv
// One link's weight/boundary/erasure registers with weight saturation.
// Erasure storage exists only when LINK_LOADER_ERASURE_EN is defined.
module link_param_slot
  import link_param_loader_pkg::*;
#(
  parameter int NUM_LINKS  = 16,
  parameter int MAX_WEIGHT = 2,
  parameter int SLOT_IDX   = 0,
  localparam int LINK_BIT_WIDTH = link_bit_width(MAX_WEIGHT),
  localparam int IDX_WIDTH      = $clog2(NUM_LINKS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IDX_WIDTH-1:0]      idx,
  input  logic                      param_we,
  input  logic                      erase_we,
  input  logic                      erase_clr,
  input  logic [LINK_BIT_WIDTH+1:0] data,
  output logic [LINK_BIT_WIDTH-1:0] weight,
  output logic [1:0]                bc,
  output logic                      erased
);

  localparam logic [LINK_BIT_WIDTH-1:0] WEIGHT_SAT = LINK_BIT_WIDTH'(MAX_WEIGHT);

  logic                      sel;
  logic [LINK_BIT_WIDTH-1:0] raw_weight;
  logic [LINK_BIT_WIDTH-1:0] weight_d, weight_q;
  logic [1:0]                bc_d, bc_q;

  assign sel        = (idx == IDX_WIDTH'(SLOT_IDX));
  assign raw_weight = data[LINK_BIT_WIDTH+1:2];

  always_comb begin
    weight_d = weight_q;
    bc_d     = bc_q;
    if (param_we && sel) begin
      weight_d = (raw_weight > WEIGHT_SAT) ? WEIGHT_SAT : raw_weight;
      bc_d     = data[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_q <= '0;
      bc_q     <= '0;
    end else begin
      weight_q <= weight_d;
      bc_q     <= bc_d;
    end
  end

  assign weight = weight_q;
  assign bc     = bc_q;

`ifdef LINK_LOADER_ERASURE_EN
  logic erased_d, erased_q;

  // Entering the erasure stage wipes every flag before new beats land.
  always_comb begin
    erased_d = erased_q;
    if (erase_clr) begin
      erased_d = 1'b0;
    end else if (erase_we && sel) begin
      erased_d = data[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erased_q <= 1'b0;
    end else begin
      erased_q <= erased_d;
    end
  end

  assign erased = erased_q;
`else
  logic unused_erase;
  assign unused_erase = ^{erase_we, erase_clr};
  assign erased       = 1'b0;
`endif

endmodule

// File: rtl/link_param_loader.sv
// Streams per-link weight/boundary beats (and optionally erasure flags when
// LINK_LOADER_ERASURE_EN is defined) into NUM_LINKS link slots.
module link_param_loader
  import link_param_loader_pkg::*;
#(
  parameter int NUM_LINKS  = 16,
  parameter int MAX_WEIGHT = 2,
  localparam int LINK_BIT_WIDTH = link_bit_width(MAX_WEIGHT),
  localparam int IDX_WIDTH      = $clog2(NUM_LINKS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [STAGE_WIDTH-1:0]              global_stage,
  input  logic                                in_valid,
  input  logic [LINK_BIT_WIDTH+1:0]           in_data,
  output logic                                in_ready,
  output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_out,
  output logic [NUM_LINKS*2-1:0]              boundary_condition_out,
  output logic [NUM_LINKS-1:0]                erased_out,
  output logic                                load_done,
  output logic                                load_incomplete
);

  loader_state_t          state_d, state_q;
  logic [IDX_WIDTH-1:0]   idx_d, idx_q;
  logic                   incomplete_d, incomplete_q;
  logic                   erase_mode_d, erase_mode_q;
  logic                   param_we, erase_we, erase_clr;
  logic [STAGE_WIDTH-1:0] active_stage;
  logic                   stage_left, last_idx;

  // erase_mode remembers which loading stage DONE must wait to see end.
  assign active_stage = erase_mode_q ? STAGE_ERASURE_LOADING : STAGE_PARAMETERS_LOADING;
  assign stage_left   = (global_stage != active_stage);
  assign last_idx     = (idx_q == IDX_WIDTH'(NUM_LINKS - 1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    incomplete_d = incomplete_q;
    erase_mode_d = erase_mode_q;
    param_we     = 1'b0;
    erase_we     = 1'b0;
    erase_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (global_stage == STAGE_PARAMETERS_LOADING) begin
          state_d      = S_LOAD_PARAM;
          incomplete_d = 1'b0;
          erase_mode_d = 1'b0;
        end
`ifdef LINK_LOADER_ERASURE_EN
        else if (global_stage == STAGE_ERASURE_LOADING) begin
          state_d      = S_LOAD_ERASE;
          incomplete_d = 1'b0;
          erase_mode_d = 1'b1;
          erase_clr    = 1'b1;
        end
`endif
      end
      S_LOAD_PARAM, S_LOAD_ERASE: begin
        if (in_valid) begin
          param_we = (state_q == S_LOAD_PARAM);
          erase_we = (state_q == S_LOAD_ERASE);
          idx_d    = idx_q + IDX_WIDTH'(1);
        end
        // A final beat wins over a simultaneous stage change.
        if (in_valid && last_idx) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else if (stage_left) begin
          state_d      = S_IDLE;
          incomplete_d = 1'b1;
          idx_d        = '0;
        end
      end
      S_DONE: begin
        idx_d = '0;
        if (stage_left) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      incomplete_q <= 1'b0;
      erase_mode_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      incomplete_q <= incomplete_d;
      erase_mode_q <= erase_mode_d;
    end
  end

  assign in_ready        = (state_q == S_LOAD_PARAM) || (state_q == S_LOAD_ERASE);
  assign load_done       = (state_q == S_DONE);
  assign load_incomplete = incomplete_q;

  for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_slot
    link_param_slot #(
      .NUM_LINKS  (NUM_LINKS),
      .MAX_WEIGHT (MAX_WEIGHT),
      .SLOT_IDX   (gi)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .idx       (idx_q),
      .param_we  (param_we),
      .erase_we  (erase_we),
      .erase_clr (erase_clr),
      .data      (in_data),
      .weight    (weight_out[gi*LINK_BIT_WIDTH +: LINK_BIT_WIDTH]),
      .bc        (boundary_condition_out[gi*2 +: 2]),
      .erased    (erased_out[gi])
    );
  end

endmodule

// File: tb/tb_link_param_loader.sv
// Scoreboard bench for link_param_loader: stimulus pushes expected slot
// contents per beat, a negedge monitor pops and compares on each accept.
module tb_link_param_loader;
  import link_param_loader_pkg::*;

  localparam int NL  = 16;
  localparam int LBW = 2;

  logic                   clk;
  logic                   reset;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   in_valid;
  logic [LBW+1:0]         in_data;
  logic                   in_ready;
  logic [NL*LBW-1:0]      weight_out;
  logic [NL*2-1:0]        boundary_condition_out;
  logic [NL-1:0]          erased_out;
  logic                   load_done;
  logic                   load_incomplete;

  link_param_loader #(.NUM_LINKS(NL), .MAX_WEIGHT(2)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .global_stage           (global_stage),
    .in_valid               (in_valid),
    .in_data                (in_data),
    .in_ready               (in_ready),
    .weight_out             (weight_out),
    .boundary_condition_out (boundary_condition_out),
    .erased_out             (erased_out),
    .load_done              (load_done),
    .load_incomplete        (load_incomplete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] w;
    logic [1:0] bc;
    logic       e;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] exp_w  [NL];
  logic [1:0] exp_bc [NL];
  logic       exp_e  [NL];
  int         nvec  = 0;
  int         nfail = 0;
  bit         pend  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [NL*LBW-1:0] pack_w();
    logic [NL*LBW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*LBW +: LBW] = exp_w[i];
    return v;
  endfunction

  function automatic logic [NL*2-1:0] pack_bc();
    logic [NL*2-1:0] v;
    for (int i = 0; i < NL; i++) v[i*2 +: 2] = exp_bc[i];
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NL; i++) begin
      exp_w[i] = '0; exp_bc[i] = '0; exp_e[i] = 1'b0;
    end
  endtask

  // Monitor: a handshake seen at one negedge is checked at the next one.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] act;
    if (pend && !reset && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {weight_out[e.idx*LBW +: LBW], boundary_condition_out[e.idx*2 +: 2], erased_out[e.idx]};
      check($sformatf("slot%0d", e.idx), {59'd0, act}, {59'd0, e.w, e.bc, e.e});
    end
    pend = 1'b0;
    if (in_valid && in_ready && !reset) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_accept: got accept of %0h expected in_ready=0", in_data);
      end else begin
        pend = 1'b1;
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input int idx, input logic [3:0] d, input bit is_erase);
    exp_t e;
    bit   done;
    if (is_erase) begin
      exp_e[idx] = d[0];
    end else begin
      exp_w[idx]  = (d[3:2] > 2'd2) ? 2'd2 : d[3:2];
      exp_bc[idx] = d[1:0];
    end
    e = '{idx, exp_w[idx], exp_bc[idx], exp_e[idx]};
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_data  = d;
    done     = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      nvec++;
      nfail++;
      $display("FAIL accept_timeout idx%0d: got in_ready=0 for 40 cycles expected accept", idx);
      void'(exp_q.pop_back());
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    global_stage = STAGE_IDLE;
    in_valid     = 1'b0;
    in_data      = '0;
    clear_model();
    idle(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_incomplete", load_incomplete, 0);
    check("rst_weight", weight_out, 0);
    check("rst_bc", boundary_condition_out, 0);
    check("rst_erased", erased_out, 0);
    reset = 1'b0;
    idle(2);

    // Asynchronous reset in the middle of a parameter load (idx = 5).
    global_stage = STAGE_PARAMETERS_LOADING;
    for (int i = 0; i < 5; i++) send(i, {2'd1, 2'd2}, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    reset        = 1'b1;
    global_stage = STAGE_IDLE;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_load_done", load_done, 0);
    check("midrst_weight", weight_out, 0);
    check("midrst_bc", boundary_condition_out, 0);
    clear_model();
    idle(1);
    reset = 1'b0;
    idle(2);

    // Full continuous load: weight = i%3, bc = i%4.
    global_stage = STAGE_PARAMETERS_LOADING;
    for (int i = 0; i < NL; i++) begin
      send(i, {2'(i % 3), 2'(i % 4)}, 1'b0);
      if (i == NL - 2) check("done_before_last", load_done, 0);
    end
    check("done_after_last", load_done, 1);
    check("ready_after_last", in_ready, 0);
    check("incomplete_full", load_incomplete, 0);
    in_valid = 1'b1;
    in_data  = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("ready_in_done", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_weight", weight_out, 32'h2492_4924);
    check("full_bc", boundary_condition_out, 32'hE4E4_E4E4);
    global_stage = STAGE_IDLE;
    idle(2);
    check("done_cleared", load_done, 0);

    // Early abort after 7 beats of weight 3 (saturates to 2), bc 1.
    global_stage = STAGE_PARAMETERS_LOADING;
    for (int i = 0; i < 7; i++) send(i, 4'hD, 1'b0);
    in_valid     = 1'b0;
    global_stage = STAGE_IDLE;
    idle(2);
    check("abort_incomplete", load_incomplete, 1);
    check("abort_in_ready", in_ready, 0);
    check("abort_load_done", load_done, 0);
    check("abort_slot6_w", weight_out[13:12], 2);
    check("abort_slot7_w", weight_out[15:14], 1);
    check("abort_weight", weight_out, pack_w());
    check("abort_bc", boundary_condition_out, pack_bc());

    // Full load with random valid gaps restores the i%3 / i%4 pattern.
    global_stage = STAGE_PARAMETERS_LOADING;
    idle(1);
    check("incomplete_cleared", load_incomplete, 0);
    for (int i = 0; i < NL; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        in_valid = 1'b0;
        idle(gap);
      end
      send(i, {2'(i % 3), 2'(i % 4)}, 1'b0);
    end
    in_valid = 1'b0;
    check("gap_done", load_done, 1);
    check("gap_weight", weight_out, 32'h2492_4924);
    check("gap_bc", boundary_condition_out, 32'hE4E4_E4E4);
    global_stage = STAGE_IDLE;
    idle(2);

    // Stage drops in the same cycle as the final beat: completes, then idles.
    global_stage = STAGE_PARAMETERS_LOADING;
    for (int i = 0; i < NL - 1; i++) send(i, {2'd0, 2'd3}, 1'b0);
    global_stage = STAGE_IDLE;
    send(NL - 1, {2'd2, 2'd0}, 1'b0);
    in_valid = 1'b0;
    check("race_done", load_done, 1);
    check("race_incomplete", load_incomplete, 0);
    idle(1);
    check("race_done_drop", load_done, 0);
    check("race_weight", weight_out, 32'h8000_0000);
    check("race_bc", boundary_condition_out, 32'h3FFF_FFFF);

    // Erasure stage: beats 1,0,1,... with nonzero weight bits that must be ignored.
    global_stage = STAGE_ERASURE_LOADING;
`ifdef LINK_LOADER_ERASURE_EN
    for (int i = 0; i < NL; i++) exp_e[i] = 1'b0;
    for (int i = 0; i < NL; i++) send(i, {3'b110, (i % 2 == 0)}, 1'b1);
    in_valid = 1'b0;
    check("erase_done", load_done, 1);
    check("erase_flags", erased_out, 16'h5555);
    check("erase_weight", weight_out, 32'h8000_0000);
    check("erase_bc", boundary_condition_out, 32'h3FFF_FFFF);
`else
    in_valid = 1'b1;
    in_data  = 4'hD;
    repeat (4) begin
      @(negedge clk);
      check("noerase_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("noerase_flags", erased_out, 0);
    check("noerase_done", load_done, 0);
    check("noerase_weight", weight_out, 32'h8000_0000);
`endif
    global_stage = STAGE_IDLE;
    idle(3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
